// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the mac_engine block.
//   - mac_state_e : FSM state encoding (IDLE / RUN / DONE)
//   - LANES       : default number of weight/data lanes per dot product
//   - W_BITS      : weight width per lane (2-bit two's complement, -2..+1)
//   - D_BITS      : activation width per lane (8-bit unsigned)
//   - PROD_W      : width of one signed lane product
//   - ACC_W       : default signed accumulator / result width
package mac_pkg;

    localparam int LANES  = 16;
    localparam int W_BITS = 2;
    localparam int D_BITS = 8;
    localparam int PROD_W = W_BITS + D_BITS;
    localparam int ACC_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mac_lane_mult.sv
// mac_lane_mult: combinational product of one signed 2-bit weight and one
// unsigned 8-bit activation.
// Ports:
//   w : input  [1:0]  weight, two's complement (-2..+1)
//   d : input  [7:0]  activation, unsigned (0..255)
//   p : output [9:0]  signed product (-510..+255)
module mac_lane_mult
    import mac_pkg::*;
(
    input  logic [W_BITS-1:0] w,
    input  logic [D_BITS-1:0] d,
    output logic [PROD_W-1:0] p
);

    logic signed [PROD_W-1:0] w_ext_s;
    logic signed [PROD_W-1:0] d_ext_s;

    // Extend both operands to the product width (weight signed, data unsigned)
    // so the multiply is a plain same-width signed operation.
    always_comb begin
        w_ext_s = {{(PROD_W-W_BITS){w[W_BITS-1]}}, w};
        d_ext_s = {{(PROD_W-D_BITS){1'b0}}, d};
        p       = w_ext_s * d_ext_s;
    end

endmodule

// File: rtl/mac_engine.sv
// mac_engine: sequential dot-product engine. On start it captures all lane
// weights and activations, then accumulates one lane product per clock for
// LANES cycles and presents the signed sum until the consumer acknowledges it.
// Ports:
//   clk, rst      : clock; synchronous active-high reset
//   clear         : synchronous abort back to IDLE (beats start / result_ack)
//   start         : begin a dot product over weights/data (IDLE or DONE+ack)
//   weights[2N-1:0]: lane i weight at [2i+1:2i], two's complement
//   data[8N-1:0]  : lane i activation at [8i+7:8i], unsigned
//   busy          : high while accumulating (RUN)
//   result_valid  : high while result is presented (DONE)
//   result        : registered signed dot product
//   result_ack    : consumer accepts result (only acted on in DONE)
// Build option: define MAC_ENGINE_RELU_EN to clamp negative results to zero.
module mac_engine #(
    parameter int LANES = mac_pkg::LANES,
    parameter int ACC_W = mac_pkg::ACC_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             start,
    input  logic [mac_pkg::W_BITS*LANES-1:0] weights,
    input  logic [mac_pkg::D_BITS*LANES-1:0] data,
    output logic                             busy,
    output logic                             result_valid,
    output logic [ACC_W-1:0]                 result,
    input  logic                             result_ack
);

    import mac_pkg::*;

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    mac_state_e                 state_r;
    mac_state_e                 state_nxt_s;
    logic                       load_s;
    logic [IDX_W-1:0]           idx_r;
    logic [ACC_W-1:0]           acc_r;
    logic [W_BITS*LANES-1:0]    w_op_r;
    logic [D_BITS*LANES-1:0]    d_op_r;
    logic [ACC_W-1:0]           result_r;
    logic                       busy_r;
    logic                       result_valid_r;

    logic [W_BITS-1:0]          w_lane_s [LANES];
    logic [D_BITS-1:0]          d_lane_s [LANES];
    logic [W_BITS-1:0]          w_sel_s;
    logic [D_BITS-1:0]          d_sel_s;
    logic [PROD_W-1:0]          prod_s;
    logic [ACC_W-1:0]           acc_sum_s;
    logic [ACC_W-1:0]           result_nxt_s;

    // Split the captured operand words into per-lane fields.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lane_s[g] = w_op_r[g*W_BITS +: W_BITS];
        assign d_lane_s[g] = d_op_r[g*D_BITS +: D_BITS];
    end

    // Lane selection muxes driven by the running lane index.
    always_comb begin
        w_sel_s = w_lane_s[idx_r];
        d_sel_s = d_lane_s[idx_r];
    end

    mac_lane_mult u_mult (
        .w (w_sel_s),
        .d (d_sel_s),
        .p (prod_s)
    );

    // Accumulate the sign-extended lane product; the sum range fits ACC_W.
    always_comb begin
        acc_sum_s = acc_r + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    end

`ifdef MAC_ENGINE_RELU_EN
    // Clamp a negative final sum to zero.
    always_comb begin
        if (acc_sum_s[ACC_W-1]) begin
            result_nxt_s = {ACC_W{1'b0}};
        end else begin
            result_nxt_s = acc_sum_s;
        end
    end
`else
    // Final sum is presented unmodified.
    always_comb begin
        result_nxt_s = acc_sum_s;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; load_s marks the edge that captures fresh operands.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        if (clear) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (result_ack) begin
                        if (start) begin
                            state_nxt_s = ST_RUN;
                            load_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: operand capture, accumulation, registered status and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r          <= {IDX_W{1'b0}};
            acc_r          <= {ACC_W{1'b0}};
            w_op_r         <= {(W_BITS*LANES){1'b0}};
            d_op_r         <= {(D_BITS*LANES){1'b0}};
            result_r       <= {ACC_W{1'b0}};
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            busy_r         <= (state_nxt_s == ST_RUN);
            result_valid_r <= (state_nxt_s == ST_DONE);
            if (clear) begin
                idx_r    <= {IDX_W{1'b0}};
                acc_r    <= {ACC_W{1'b0}};
                result_r <= {ACC_W{1'b0}};
            end else if (load_s) begin
                w_op_r <= weights;
                d_op_r <= data;
                idx_r  <= {IDX_W{1'b0}};
                acc_r  <= {ACC_W{1'b0}};
            end else if (state_r == ST_RUN) begin
                acc_r <= acc_sum_s;
                if (idx_r == LAST_IDX) begin
                    idx_r    <= {IDX_W{1'b0}};
                    result_r <= result_nxt_s;
                end else begin
                    idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign result       = result_r;

endmodule

// File: doc/mac_engine.md
MAC_ENGINE -- requirements
Module: mac_engine

Interface
REQ-001 Parameter LANES, default 16, number of weight/data lanes per dot product.
REQ-002 Parameter ACC_W, default 16, signed accumulator and result width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clear  input  1  synchronous abort; returns the block to IDLE.
REQ-006 start  input  1  request one dot product over the current weights/data.
REQ-007 weights  input  32  lane i weight = weights[2i+1:2i], 2-bit two's complement (-2..+1).
REQ-008 data  input  128  lane i activation = data[8i+7:8i], 8-bit unsigned.
REQ-009 busy  output  1  high in RUN.
REQ-010 result_valid  output  1  high in DONE.
REQ-011 result  output  ACC_W  signed dot product; valid only while result_valid is high.
REQ-012 result_ack  input  1  consumer accepts result; meaningful only in DONE.

Function
REQ-013 FSM states IDLE, RUN, DONE; encoding SHALL come from the package.
REQ-014 IDLE: start=1 SHALL latch weights and data into internal operand registers, clear acc, set lane index 0, go RUN.
REQ-015 RUN: each edge SHALL perform acc += sext(w[idx]) * zext(d[idx]), idx += 1.
REQ-016 RUN: the edge that processes idx = LANES-1 SHALL go DONE; RUN lasts exactly LANES cycles.
REQ-017 Latency: start sampled at edge k -> result_valid high after edge k+LANES (16 cycles).
REQ-018 start during RUN SHALL be ignored; operand registers SHALL NOT change after capture.
REQ-019 DONE: result and result_valid SHALL hold until result_ack=1.
REQ-020 DONE, result_ack=1, start=0 -> IDLE; result_valid low next cycle.
REQ-021 DONE, result_ack=1, start=1 -> back-to-back: new operands latched, go RUN directly.
REQ-022 result_ack outside DONE SHALL be ignored.
REQ-023 Arithmetic: product range -510..+255, sum range -8160..+4080; the 16-bit accumulator SHALL never overflow, no saturation logic.
REQ-024 clear=1 in any state -> IDLE next edge, acc cleared, busy/result_valid low; clear SHALL take priority over start and result_ack.
REQ-025 result SHALL be registered (no combinational path from inputs).

Reset
REQ-026 rst=1 SHALL force IDLE, idx=0, acc=0, operands=0, busy=0, result_valid=0, result=0.
REQ-027 rst SHALL take priority over clear, start and result_ack, including mid-RUN.

Configuration
REQ-028 Macro MAC_ENGINE_RELU_EN defined: result = max(acc, 0) in DONE.
REQ-029 Macro MAC_ENGINE_RELU_EN undefined: result = acc unmodified (signed).

Structure
REQ-030 Package mac_pkg SHALL hold the state enum, LANES, W_BITS=2, D_BITS=8, ACC_W defaults.
REQ-031 Sub-module mac_lane_mult SHALL compute one signed 2-bit x unsigned 8-bit product (combinational, 10-bit signed out).
REQ-032 Lane selection muxes and the FSM SHALL live in mac_engine.

Verification
REQ-033 All weights 2'b01, all data 8'hFF, start 1 cycle -> busy 16 cycles, then result=16'h0FF0 (4080), result_valid held until ack.
REQ-034 All weights 2'b10, all data 8'hFF -> result=16'hE020 (-8160) without RELU; 16'h0000 with MAC_ENGINE_RELU_EN.
REQ-035 Lane 0 weight 2'b11, data 8'h05, all other weights 2'b00 -> result=16'hFFFB (-5); inputs changed during RUN do not alter it.
REQ-036 clear at 8th RUN cycle -> IDLE next edge, busy=0, result_valid never asserts; rst mid-RUN gives same with all outputs 0.
REQ-037 In DONE, result_ack and start together with all weights 2'b01, data 8'h01 -> result_valid low next cycle, new result 16'h0010 after 16 more cycles.
